mux_8to1: RTL and testbench

- Registered 8-to-1 multiplexer with one-cycle latency.
- Selects one of eight DATA_W-bit lanes packed in data_in, using sel.
- Output is registered on clk; a valid qualifier travels with the data.
- Used as a lane selector in datapath and control paths that need a glitch-free, clock-aligned single-bit (default) output.

---
 rtl/mux_8to1_pkg.sv | 15 +
 rtl/mux_8to1_comb.sv | 35 +++
 rtl/mux_8to1.sv | 55 +++++
 tb/tb_mux_8to1.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mux_8to1_pkg.sv
// ============================================================================
// Module      : mux_8to1_pkg
// Description : Shared lane-count and select-width constants for mux_8to1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_8to1_pkg;

    localparam int unsigned c_lanes = 8;
    localparam int unsigned c_sel_w = 3;

endpackage : mux_8to1_pkg

`default_nettype wire

// File: rtl/mux_8to1_comb.sv
// ============================================================================
// Module      : mux_8to1_comb
// Description : Pure combinational 8-lane selector; lane k sits at [k*DATA_W +: DATA_W].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_8to1_comb
    import mux_8to1_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic [c_lanes*DATA_W-1:0] data_in,
    input  logic [c_sel_w-1:0]        sel,
    output logic [DATA_W-1:0]         lane_out
);

    // Every select code is a real lane; the leading default only keeps the block latch-free.
    always_comb begin
        lane_out = '0;
        case (sel)
            3'd0: lane_out = data_in[0*DATA_W +: DATA_W];
            3'd1: lane_out = data_in[1*DATA_W +: DATA_W];
            3'd2: lane_out = data_in[2*DATA_W +: DATA_W];
            3'd3: lane_out = data_in[3*DATA_W +: DATA_W];
            3'd4: lane_out = data_in[4*DATA_W +: DATA_W];
            3'd5: lane_out = data_in[5*DATA_W +: DATA_W];
            3'd6: lane_out = data_in[6*DATA_W +: DATA_W];
            3'd7: lane_out = data_in[7*DATA_W +: DATA_W];
        endcase
    end

endmodule : mux_8to1_comb

`default_nettype wire

// File: rtl/mux_8to1.sv
// ============================================================================
// Module      : mux_8to1
// Description : Registered 8-to-1 lane multiplexer, one-cycle latency, valid travels with data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_8to1
    import mux_8to1_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [c_lanes*DATA_W-1:0] data_in,
    input  logic [c_sel_w-1:0]        sel,
    input  logic                      in_valid,
    output logic [DATA_W-1:0]         data_out,
    output logic                      out_valid,
    output logic [c_sel_w-1:0]        sel_q
);

    logic [DATA_W-1:0]  w_lane;
    logic [DATA_W-1:0]  r_data_out;
    logic               r_out_valid;
    logic [c_sel_w-1:0] r_sel_q;

    mux_8to1_comb #(
        .DATA_W   (DATA_W)
    ) u_comb (
        .data_in  (data_in),
        .sel      (sel),
        .lane_out (w_lane)
    );

    // Data and sel capture every cycle; in_valid only qualifies the result downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_sel_q     <= '0;
        end else begin
            r_data_out  <= w_lane;
            r_out_valid <= in_valid;
            r_sel_q     <= sel;
        end
    end

    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign sel_q     = r_sel_q;

endmodule : mux_8to1

`default_nettype wire

// File: tb/tb_mux_8to1.sv
// ============================================================================
// Module      : tb_mux_8to1
// Description : Scoreboard bench for mux_8to1 (DATA_W=1 and DATA_W=4 builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_8to1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic [2:0]  sel;
    logic        in_valid;
    logic        data_out;
    logic        out_valid;
    logic [2:0]  sel_q;

    logic [31:0] data_in4;
    logic [2:0]  sel4;
    logic        in_valid4;
    logic [3:0]  data_out4;
    logic        out_valid4;
    logic [2:0]  sel_q4;

    always #5 clk = ~clk;

    mux_8to1 #(.DATA_W(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .sel       (sel),
        .in_valid  (in_valid),
        .data_out  (data_out),
        .out_valid (out_valid),
        .sel_q     (sel_q)
    );

    mux_8to1 #(.DATA_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in4),
        .sel       (sel4),
        .in_valid  (in_valid4),
        .data_out  (data_out4),
        .out_valid (out_valid4),
        .sel_q     (sel_q4)
    );

    typedef struct packed {
        logic       data;
        logic       valid;
        logic [2:0] sel;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Apply one cycle of stimulus, record the expected outputs, advance past the edge.
    task automatic drive(input logic r, input logic [7:0] d, input logic [2:0] s, input logic v);
        exp_t e;
        rst      = r;
        data_in  = d;
        sel      = s;
        in_valid = v;
        if (r) begin
            e = '0;
        end else begin
            e.data  = d[s];
            e.valid = v;
            e.sel   = s;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'hFF, 3'd3, 1'b1);
            e = sb.pop_front();
            n_cmp++;
            if ({data_out, out_valid, sel_q} !== {e.data, e.valid, e.sel}) begin
                n_err++;
                $display("FAIL reset[%0d]: got data=%b valid=%b sel_q=%0d, want data=%b valid=%b sel_q=%0d",
                         i, data_out, out_valid, sel_q, e.data, e.valid, e.sel);
            end
        end
    endtask

    task automatic test_walking_one();
        exp_t e;
        logic [7:0] d_tab [3] = '{8'b0000_0001, 8'b1000_0000, 8'b1000_0000};
        logic [2:0] s_tab [3] = '{3'd0, 3'd0, 3'd7};
        logic       want  [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, d_tab[i], s_tab[i], 1'b1);
            e = sb.pop_front();
            n_cmp++;
            if (data_out !== want[i] || {data_out, out_valid, sel_q} !== {e.data, e.valid, e.sel}) begin
                n_err++;
                $display("FAIL walking_one[%0d]: got data=%b valid=%b sel_q=%0d, want data=%b valid=%b sel_q=%0d",
                         i, data_out, out_valid, sel_q, want[i], e.valid, e.sel);
            end
        end
    endtask

    task automatic test_directed_lanes();
        exp_t e;
        logic [7:0] d_tab [3] = '{8'b0000_0010, 8'b0000_0010, 8'b0000_1000};
        logic [2:0] s_tab [3] = '{3'd1, 3'd2, 3'd3};
        logic       want  [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, d_tab[i], s_tab[i], 1'b1);
            e = sb.pop_front();
            n_cmp++;
            if (data_out !== want[i] || {data_out, out_valid, sel_q} !== {e.data, e.valid, e.sel}) begin
                n_err++;
                $display("FAIL directed[%0d]: got data=%b valid=%b sel_q=%0d, want data=%b valid=%b sel_q=%0d",
                         i, data_out, out_valid, sel_q, want[i], e.valid, e.sel);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int s = 0; s < 8; s++) begin
            for (int d = 0; d < 256; d++) begin
                drive(1'b0, 8'(d), 3'(s), 1'b1);
                e = sb.pop_front();
                n_cmp++;
                if ({data_out, out_valid, sel_q} !== {e.data, e.valid, e.sel}) begin
                    n_err++;
                    $display("FAIL sweep sel=%0d data_in=%02h: got data=%b valid=%b sel_q=%0d, want data=%b valid=%b sel_q=%0d",
                             s, d, data_out, out_valid, sel_q, e.data, e.valid, e.sel);
                end
            end
        end
    endtask

    task automatic test_valid_and_reset();
        exp_t e;
        logic       r_tab [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] d_tab [6] = '{8'h04, 8'h00, 8'h40, 8'hAA, 8'h20, 8'h00};
        logic [2:0] s_tab [6] = '{3'd2, 3'd2, 3'd6, 3'd5, 3'd5, 3'd4};
        logic       v_tab [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(r_tab[i], d_tab[i], s_tab[i], v_tab[i]);
            e = sb.pop_front();
            n_cmp++;
            if ({data_out, out_valid, sel_q} !== {e.data, e.valid, e.sel}) begin
                n_err++;
                $display("FAIL valid_reset[%0d]: got data=%b valid=%b sel_q=%0d, want data=%b valid=%b sel_q=%0d",
                         i, data_out, out_valid, sel_q, e.data, e.valid, e.sel);
            end
        end
    endtask

    task automatic test_wide_lane();
        data_in4  = 32'h7654_3210;
        sel4      = 3'd5;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        data_in4 = 32'h0;
        sel4     = 3'd0;
        n_cmp++;
        if ({data_out4, out_valid4, sel_q4} !== {4'h5, 1'b1, 3'd5}) begin
            n_err++;
            $display("FAIL wide_lane: got data=%h valid=%b sel_q=%0d, want data=5 valid=1 sel_q=5",
                     data_out4, out_valid4, sel_q4);
        end
    endtask

    initial begin
        rst       = 1'b1;
        data_in   = '0;
        sel       = '0;
        in_valid  = 1'b0;
        data_in4  = '0;
        sel4      = '0;
        in_valid4 = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_walking_one();
        test_directed_lanes();
        test_back_to_back();
        test_valid_and_reset();
        test_wide_lane();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux_8to1

`default_nettype wire
